// File: rtl/spi_sensor_phy.sv
// rtl/spi_sensor_phy.sv - SPI mode-0 single-word read engine for the temperature sensor
// Registered outputs only; one transfer per spi_start_i accepted in IDLE.
module spi_sensor_phy #(
  parameter int CLK_DIV   = 4,
  parameter int DATA_BITS = 8,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_start_i,
  input  logic                 miso_i,
  output logic                 sclk_o,
  output logic                 cs_n_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_ready_o,
  output logic                 busy_o
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                           ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int TGL_W = $clog2(2 * DATA_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [TGL_W-1:0] TGL_LAST   = TGL_W'(2 * DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TGL_W-1:0]     tgl_q, tgl_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tgl_q      <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgl_q      <= tgl_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // cnt_q is shared: setup timer, SCLK half-period divider, then hold timer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgl_d   = tgl_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      IDLE: begin
        if (spi_start_i) begin
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tgl_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          tgl_d  = tgl_q + TGL_W'(1);
          if (!sclk_q) begin
            shreg_d = (shreg_q << 1) | DATA_BITS'(miso_i);
          end
          if (tgl_q == TGL_LAST) begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge
  always_comb begin
    busy_d     = (state_d != IDLE);
    cs_n_d     = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    rx_ready_d = (state_d == DONE);
    rx_data_d  = rx_data_q;
    if ((state_q == HOLD) && (state_d == DONE)) begin
      rx_data_d = shreg_q;
    end
  end

  assign sclk_o     = sclk_q;
  assign cs_n_o     = cs_n_q;
  assign rx_data_o  = rx_data_q;
  assign rx_ready_o = rx_ready_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_sensor_phy.sv
// tb/tb_spi_sensor_phy.sv - randomized self-checking bench for spi_sensor_phy
module tb_spi_sensor_phy;

  localparam int CD1 = 4, DB1 = 8, CS1 = 2, CH1 = 2;
  localparam int T1 = CS1 + 2 * DB1 * CD1 + CH1;
  localparam int CD2 = 2, DB2 = 12, CS2 = 1, CH2 = 1;
  localparam int T2 = CS2 + 2 * DB2 * CD2 + CH2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, miso1 = 1'b0;
  logic start2 = 1'b0, miso2 = 1'b0;
  logic sclk1, cs_n1, rdy1, busy1;
  logic sclk2, cs_n2, rdy2, busy2;
  logic [DB1-1:0] rdata1;
  logic [DB2-1:0] rdata2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_sensor_phy dut1 (
    .clk(clk), .rst(rst), .spi_start_i(start1), .miso_i(miso1),
    .sclk_o(sclk1), .cs_n_o(cs_n1), .rx_data_o(rdata1),
    .rx_ready_o(rdy1), .busy_o(busy1)
  );

  spi_sensor_phy #(.CLK_DIV(CD2), .DATA_BITS(DB2), .CS_SETUP(CS2), .CS_HOLD(CH2)) dut2 (
    .clk(clk), .rst(rst), .spi_start_i(start2), .miso_i(miso2),
    .sclk_o(sclk2), .cs_n_o(cs_n2), .rx_data_o(rdata2),
    .rx_ready_o(rdy2), .busy_o(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {cs_n, sclk, busy, rx_ready} d edges after the accepting edge
  function automatic logic [3:0] expect_out(input int d, input int cs, input int cd,
                                            input int db, input int ch);
    int  t;
    logic s;
    t = cs + 2 * db * cd + ch;
    if (d >= 0 && d < t) begin
      s = (d > cs && d <= cs + 2 * db * cd) ? (((d - cs) / cd) % 2 == 1) : 1'b0;
      return {1'b0, s, 1'b1, 1'b0};
    end
    if (d == t) return 4'b1011;
    return 4'b1000;
  endfunction

  // Sensor models: load a word when cs_n falls, advance on each sclk fall
  logic [DB1-1:0] sens_q1[$];
  logic [DB1-1:0] sword1 = '0;
  int sidx1 = 0;
  always @(negedge cs_n1) begin
    if (sens_q1.size() > 0) sword1 = sens_q1.pop_front();
    else sword1 = '0;
    sidx1 = DB1 - 1;
    miso1 = sword1[sidx1];
  end
  always @(negedge sclk1) begin
    if (sidx1 > 0) begin
      sidx1--;
      miso1 = sword1[sidx1];
    end
  end

  logic [DB2-1:0] sens_q2[$];
  logic [DB2-1:0] sword2 = '0;
  int sidx2 = 0;
  always @(negedge cs_n2) begin
    if (sens_q2.size() > 0) sword2 = sens_q2.pop_front();
    else sword2 = '0;
    sidx2 = DB2 - 1;
    miso2 = sword2[sidx2];
  end
  always @(negedge sclk2) begin
    if (sidx2 > 0) begin
      sidx2--;
      miso2 = sword2[sidx2];
    end
  end

  // Reference model and cycle monitor for dut1
  logic [DB1-1:0] exp_q1[$];
  logic [DB1-1:0] word1 = '0, exp_data1 = '0;
  logic [3:0] e1;
  logic sclk_prev1 = 1'b0;
  int cyc1 = 0, e0_1 = -1000, rdy_cnt1 = 0, rise_cnt1 = 0;
  int rdy_cyc1 = 0, rdy_gap1 = 0, csn_run1 = 0, csn_gap1 = 0;
  always @(posedge clk) begin
    cyc1++;
    if (rst) begin
      e0_1 = -1000;
      exp_data1 = '0;
    end else begin
      if (start1 && (cyc1 - e0_1 >= T1 + 2)) begin
        e0_1 = cyc1;
        if (exp_q1.size() > 0) word1 = exp_q1.pop_front();
        else word1 = '0;
      end
      if (cyc1 - e0_1 == T1) exp_data1 = word1;
    end
    e1 = expect_out(cyc1 - e0_1, CS1, CD1, DB1, CH1);
    #1;
    check("d1_cs_n", cs_n1, e1[3]);
    check("d1_sclk", sclk1, e1[2]);
    check("d1_busy", busy1, e1[1]);
    check("d1_rx_ready", rdy1, e1[0]);
    check("d1_rx_data", rdata1, exp_data1);
    if (sclk1 && !sclk_prev1) rise_cnt1++;
    sclk_prev1 = sclk1;
    if (rdy1) begin
      rdy_gap1 = cyc1 - rdy_cyc1;
      rdy_cyc1 = cyc1;
      rdy_cnt1++;
    end
    if (cs_n1) csn_run1++;
    else begin
      if (csn_run1 > 0) csn_gap1 = csn_run1;
      csn_run1 = 0;
    end
  end

  // Reference model and cycle monitor for dut2
  logic [DB2-1:0] exp_q2[$];
  logic [DB2-1:0] word2 = '0, exp_data2 = '0;
  logic [3:0] e2;
  logic sclk_prev2 = 1'b0;
  int cyc2 = 0, e0_2 = -1000, rdy_cnt2 = 0, rise_cnt2 = 0, rdy_cyc2 = 0;
  always @(posedge clk) begin
    cyc2++;
    if (rst) begin
      e0_2 = -1000;
      exp_data2 = '0;
    end else begin
      if (start2 && (cyc2 - e0_2 >= T2 + 2)) begin
        e0_2 = cyc2;
        if (exp_q2.size() > 0) word2 = exp_q2.pop_front();
        else word2 = '0;
      end
      if (cyc2 - e0_2 == T2) exp_data2 = word2;
    end
    e2 = expect_out(cyc2 - e0_2, CS2, CD2, DB2, CH2);
    #1;
    check("d2_cs_n", cs_n2, e2[3]);
    check("d2_sclk", sclk2, e2[2]);
    check("d2_busy", busy2, e2[1]);
    check("d2_rx_ready", rdy2, e2[0]);
    check("d2_rx_data", rdata2, exp_data2);
    if (sclk2 && !sclk_prev2) rise_cnt2++;
    sclk_prev2 = sclk2;
    if (rdy2) begin
      rdy_cyc2 = cyc2;
      rdy_cnt2++;
    end
  end

  task automatic xfer1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic xfer2();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
  endtask

  int r0, k0, i;
  logic [DB1-1:0] w;
  logic [DB2-1:0] w2;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_cs_n", cs_n1, 1'b1);
    check("rst_sclk", sclk1, 1'b0);
    check("rst_rx_data", rdata1, '0);
    check("rst_rx_ready", rdy1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_d2_rx_data", rdata2, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0 = rise_cnt1;
    repeat (20) @(negedge clk);
    check("idle_no_sclk", rise_cnt1 - r0, 0);

    // single transfer
    sens_q1.push_back(8'hA5); exp_q1.push_back(8'hA5);
    r0 = rise_cnt1; k0 = rdy_cnt1;
    xfer1();
    repeat (T1 + 4) @(negedge clk);
    check("single_rises", rise_cnt1 - r0, DB1);
    check("single_rdy_cnt", rdy_cnt1 - k0, 1);
    check("single_data", rdata1, 8'hA5);

    // starts while busy are dropped
    sens_q1.push_back(8'h3C); exp_q1.push_back(8'h3C);
    k0 = rdy_cnt1;
    xfer1();
    repeat (9) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (29) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (T1 + 4 - 40) @(negedge clk);
    check("busy_ign_rdy_cnt", rdy_cnt1 - k0, 1);
    check("busy_ign_data", rdata1, 8'h3C);

    // back-to-back with start held high
    sens_q1.push_back(8'hFF); exp_q1.push_back(8'hFF);
    sens_q1.push_back(8'h00); exp_q1.push_back(8'h00);
    k0 = rdy_cnt1;
    @(negedge clk) start1 = 1'b1;
    for (int n = 0; n < 400 && (rdy_cnt1 - k0) < 2; n++) @(negedge clk);
    start1 = 1'b0;
    check("b2b_rdy_cnt", rdy_cnt1 - k0, 2);
    check("b2b_rdy_gap", rdy_gap1, T1 + 2);
    check("b2b_csn_high", csn_gap1, 2);
    check("b2b_data", rdata1, 8'h00);
    repeat (5) @(negedge clk);

    // randomized words, gaps and spurious starts during transfers
    for (i = 0; i < 6; i++) begin
      w = DB1'($urandom);
      if (i == 5) w[0] = 1'b1;
      sens_q1.push_back(w); exp_q1.push_back(w);
      start1 = 1'b1;
      @(negedge clk);
      for (int k = 1; k < T1; k++) begin
        start1 = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
      start1 = 1'b0;
      repeat (2 + $urandom_range(0, 5)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // reset in the middle of SHIFT while sclk is high
    sens_q1.push_back(8'h5A); exp_q1.push_back(8'h5A);
    k0 = rdy_cnt1;
    xfer1();
    repeat (29) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", cs_n1, 1'b1);
    check("abort_sclk", sclk1, 1'b0);
    check("abort_rx_data", rdata1, '0);
    check("abort_rx_ready", rdy1, 1'b0);
    check("abort_busy", busy1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_rdy", rdy_cnt1 - k0, 0);
    sens_q1.push_back(8'h81); exp_q1.push_back(8'h81);
    xfer1();
    repeat (T1 + 4) @(negedge clk);
    check("after_abort_rdy", rdy_cnt1 - k0, 1);
    check("after_abort_data", rdata1, 8'h81);

    // non-default parameter instance
    sens_q2.push_back(12'hABC); exp_q2.push_back(12'hABC);
    r0 = rise_cnt2; k0 = rdy_cnt2;
    xfer2();
    repeat (T2 + 4) @(negedge clk);
    check("d2_rises", rise_cnt2 - r0, DB2);
    check("d2_rdy_cnt", rdy_cnt2 - k0, 1);
    check("d2_rdy_latency", rdy_cyc2 - e0_2, 50);
    check("d2_data", rdata2, 12'hABC);
    for (i = 0; i < 3; i++) begin
      w2 = DB2'($urandom);
      sens_q2.push_back(w2); exp_q2.push_back(w2);
      xfer2();
      repeat (T2 + 1 + $urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sensor_phy.md
Name: spi_sensor_phy

Overview:
- SPI mode-0 bus engine for the temperature logger. Single-byte, read-only; MSB first.
- Connects directly to the logger's request FSM. That FSM's one-cycle `spi_start` pulse launches one byte read from the sensor.
- On completion, returns the byte as `rx_data` with a one-cycle `rx_ready` strobe.
- Generates `cs_n` and `sclk`, and samples `miso`.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal values ≥2.
- DATA_BITS, 8: bits per transfer; legal values 1..16.
- CS_SETUP, 2: clocks with cs_n low before the first SCLK rise; legal values ≥1.
- CS_HOLD, 2: clocks with cs_n low after the last SCLK fall; legal values ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spi_start  in  1  transfer request; sampled only in IDLE.
- miso  in  1  serial data from the sensor.
- sclk  out  1  SPI clock; idles low (CPOL=0).
- cs_n  out  1  chip select, active low.
- rx_data  out  DATA_BITS  last received word; holds its value between transfers.
- rx_ready  out  1  one-cycle strobe; rx_data is valid in the same cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst is asynchronous, active-high; clock is clk):
  - On assertion, outputs take these values immediately: state=IDLE, sclk=0, cs_n=1, rx_data=0, rx_ready=0, busy=0.
  - Divider counter and shift register are cleared.
  - Reset mid-transfer aborts the transfer: no rx_ready, rx_data=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - cs_n=1, sclk=0.
  - spi_start=1 at a clock edge moves to SETUP; that same edge (edge E0) drives cs_n to 0.
  - spi_start is ignored in every other state: it is neither queued nor counted.
- SETUP:
  - cs_n=0, sclk=0; lasts exactly CS_SETUP cycles, then SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1. On the terminal count, sclk toggles and the counter wraps to 0.
  - The first rising edge of sclk occurs CLK_DIV cycles after entering SHIFT.
  - On every clk edge that drives sclk 0->1, miso is shifted into the shift register LSB, shifting left. The first bit received is the MSB.
  - After 2*DATA_BITS toggles (DATA_BITS rising edges, ending with sclk low), move to HOLD.
  - SHIFT lasts exactly 2*DATA_BITS*CLK_DIV cycles.
- HOLD:
  - cs_n=0, sclk=0; lasts CS_HOLD cycles.
  - On the edge leaving HOLD: rx_data <= shift register, rx_ready <= 1, cs_n <= 1.
- DONE:
  - rx_ready=1 for exactly this one cycle; cs_n=1.
  - Unconditionally moves to IDLE; rx_ready returns to 0.
- Timing:
  - rx_ready rises at edge E0 + CS_SETUP + 2*DATA_BITS*CLK_DIV + CS_HOLD. With defaults, that is E0+68.
  - cs_n is low for exactly that many cycles.
- Back-to-back transfers:
  - If spi_start is high in the IDLE cycle after DONE, the next transfer begins.
  - Minimum cs_n high time between transfers is 2 cycles (DONE + IDLE).
- rx_data changes only at the HOLD->DONE edge and on reset.
- sclk never toggles while cs_n=1. No partial words are ever presented.

Test Plan:
- Reset: assert rst mid-idle and check the reset values. Then release rst with spi_start=0 for 20 cycles -> sclk=0, cs_n=1, busy=0, rx_ready=0, with no toggles.
- Single transfer, defaults:
  - Stimulus: pulse spi_start at edge E0; sensor model drives 0xA5 MSB-first, updating miso on sclk falling edges. Before the first rise, miso is preset to bit 7.
  - Required response: cs_n low E0..E0+68; exactly 8 sclk rising edges; first rising edge at E0+6.
  - rx_ready high for one cycle at E0+68 with rx_data=0xA5; busy low from E0+69.
- Start ignored while busy: pulse spi_start again at E0+10 and E0+40 during a 0x3C transfer -> only one transfer, one rx_ready, rx_data=0x3C. cs_n stays high after DONE.
- Back-to-back: hold spi_start high continuously; sensor sends 0xFF then 0x00.
  - Two rx_ready pulses, 70 cycles apart, with rx_data=0xFF then 0x00.
  - cs_n high for exactly 2 cycles between transfers.
- Reset mid-shift: assert rst at E0+30 during a 0x5A transfer.
  - Immediately: cs_n=1, sclk=0, rx_data=0, no rx_ready.
  - A following transfer of 0x81 completes normally with rx_data=0x81.
- Parameter sweep with CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, DATA_BITS=12; sensor sends 0xABC.
  - rx_ready at E0+50 with rx_data=0xABC.
  - 12 sclk rises, each sclk high/low phase lasting 2 cycles.
